booth_seq_multiplier: RTL and testbench
=======================================

Name: booth_seq_multiplier

Overview:
- Sequential radix-2 Booth multiplier datapath plus controller for the Booth_Multiplier design.
- Produces signed two's-complement products one Booth step per clock.
- Sits directly upstream of the multiplexer stage: its registered step decode (Q0, Q-1) drives the select inputs of the mux tree, which picks add, subtract or pass for the partial product.
- Exposes a start/busy/done handshake to the surrounding datapath.

Parameters:
- WIDTH, 16, operand width in bits. Must be at least 2. Product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, width of the internal iteration counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a multiply. Sampled only in IDLE.
- multiplicand  input  WIDTH  signed operand M. Captured on the accepting edge.
- multiplier  input  WIDTH  signed operand Q. Captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  signed result. Held until the next completion or reset.
- booth_sel  output  2  current {Q[0], Q_-1} pair, registered, for the downstream mux select.

Behaviour:
- Reset (rst=1 at an edge) forces the following, overriding everything including start:
  - state=IDLE, busy=0, done=0, product=0, booth_sel=0.
  - Internal A, Q, Q_-1, M and count cleared.
- Reset mid-operation aborts the multiply. No done is produced.
- Registers:
  - A is a WIDTH+1-bit sign-extended accumulator. It handles M = -2^(WIDTH-1) without overflow.
  - Q is WIDTH bits; Q_-1 is 1 bit; M is stored sign-extended to WIDTH+1 bits.
  - count runs 0..WIDTH.
- States: IDLE, RUN.
- IDLE:
  - If start=1: load M<=multiplicand, Q<=multiplier, A<=0, Q_-1<=0, count<=0, busy<=1, then go to RUN.
  - done is cleared each IDLE cycle unless set by the completing edge.
- RUN, one Booth step per edge, decoded from {Q[0], Q_-1}:
  - 01: A' = A + M.
  - 10: A' = A - M.
  - 00 or 11: A' = A.
  - Then arithmetic right shift of {A', Q, Q_-1} by one, with the sign of A' replicated.
  - count<=count+1.
- Completion on the edge where count==WIDTH-1 (the WIDTH-th step):
  - product <= low 2*WIDTH bits of the shifted {A, Q}.
  - done<=1, busy<=0, return to IDLE.
- Latency: start accepted at edge E0 gives done and product valid after edge E_WIDTH. That is WIDTH cycles, and done is high for exactly one cycle.
- start while busy=1 is ignored; operands are not re-captured.
- Back-to-back operation: start=1 in the cycle where done=1 is accepted at that edge. done falls and busy rises at that same edge.
- booth_sel = {Q[0], Q_-1} as registered. It is valid during RUN and 0 in IDLE after reset.
- Arithmetic is fully signed. All WIDTH-bit operand pairs, including both operands equal to -2^(WIDTH-1), give the exact product.
- No X propagation: outputs take defined values from reset onward.

Test Plan:
- Reset, then multiplicand=3, multiplier=5, start pulse:
  - busy=1 for 16 cycles.
  - done pulses after edge E16 with product=0x0000000F; busy=0.
- multiplicand=-7 (0xFFF9), multiplier=6 -> product=0xFFFFFFD6 (-42). product holds after done falls.
- Extreme operands:
  - multiplicand=0x8000, multiplier=0x8000 -> product=0x40000000.
  - multiplicand=0x8000, multiplier=0x0001 -> 0xFFFF8000.
- Start while busy:
  - Start 3*5, then at E5 assert start with operands 2*2.
  - Required: first result 0x0000000F at E16; the second request is ignored.
  - Then start 2*2 in the done cycle -> accepted; 0x00000004 arrives 16 cycles later.
- Reset during an operation:
  - Start 100*100, assert rst at E8.
  - Required: busy=0, done=0, product=0 after that edge, and no done pulse follows.
  - A fresh start of 0x7FFF*0x7FFF then yields 0x3FFF0001.
- Decode visibility:
  - multiplier=0x0002 (binary ...10), multiplicand=1.
  - booth_sel sequence over the first three RUN cycles is 00, 10, 01.
  - product=0x00000002.

Source files
------------

// File: rtl/booth_seq_multiplier.sv
// ============================================================================
// booth_seq_multiplier
// Sequential radix-2 Booth multiplier: one Booth step per clock, signed
// two's-complement operands, start/busy/done handshake, registered Booth
// step decode exported for the downstream add/subtract/pass mux select.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_seq_multiplier #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [1:0]           booth_sel
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Count value on the edge that performs the WIDTH-th (final) step.
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

   state_t             state;
   state_t             state_next;

   // acc and mcand carry one extra sign bit so that A - M with
   // M = -2^(WIDTH-1) cannot overflow the accumulator.
   logic [WIDTH:0]     acc;
   logic [WIDTH:0]     mcand;
   logic [WIDTH-1:0]   mplier;
   logic               q_m1;
   logic [CNT_W-1:0]   count;

   logic               last_step;
   logic [WIDTH:0]     acc_sum;
   logic [WIDTH:0]     acc_shift;
   logic [WIDTH-1:0]   q_shift;

   assign last_step = (count == LAST_COUNT);
   assign booth_sel = {mplier[0], q_m1};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode: leave IDLE on start, return after the final step.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start)     state_next = RUN;
         RUN:     if (last_step) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // One Booth step: add/subtract/pass on {Q0,Q-1}, then arithmetic shift right of {A,Q}.
   always_comb begin
      acc_sum = acc;
      case ({mplier[0], q_m1})
         2'b01:   acc_sum = acc + mcand;
         2'b10:   acc_sum = acc - mcand;
         default: acc_sum = acc;
      endcase
      acc_shift = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
      q_shift   = {acc_sum[0], mplier[WIDTH-1:1]};
   end

   // Datapath and handshake registers: operand capture, step update, result latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         q_m1    <= 1'b0;
         count   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand  <= {multiplicand[WIDTH-1], multiplicand};
                  mplier <= multiplier;
                  acc    <= '0;
                  q_m1   <= 1'b0;
                  count  <= '0;
                  busy   <= 1'b1;
               end
            end
            RUN: begin
               acc    <= acc_shift;
               mplier <= q_shift;
               q_m1   <= mplier[0];
               count  <= count + CNT_W'(1);
               if (last_step) begin
                  product <= {acc_shift[WIDTH-1:0], q_shift};
                  done    <= 1'b1;
                  busy    <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_multiplier.sv
// ============================================================================
// tb_booth_seq_multiplier
// Self-checking bench: transaction-level reference model (plain signed
// multiplication plus a step counter) compared on every cycle, with directed
// scenarios pinned by hand-computed literals, then randomized traffic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_seq_multiplier;

   localparam int W = 16;
   localparam int P = 2 * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  multiplicand;
   logic [W-1:0]  multiplier;
   logic          busy;
   logic          done;
   logic [P-1:0]  product;
   logic [1:0]    booth_sel;

   booth_seq_multiplier #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .booth_sel    (booth_sel)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   bit                  m_valid = 1'b0;
   bit                  m_busy;
   bit                  m_done;
   bit                  m_sel_zero;
   logic [P-1:0]        m_prod;
   int                  m_steps;
   logic signed [W-1:0] m_a;
   logic signed [W-1:0] m_q;
   logic [1:0]          e_sel;

   // Model: accept start when idle, finish after W steps with the exact signed product.
   always @(posedge clk) begin
      if (rst) begin
         m_valid    = 1'b1;
         m_busy     = 1'b0;
         m_done     = 1'b0;
         m_prod     = '0;
         m_steps    = 0;
         m_sel_zero = 1'b1;
      end else if (m_valid) begin
         m_done = 1'b0;
         if (!m_busy) begin
            if (start) begin
               m_busy     = 1'b1;
               m_a        = multiplicand;
               m_q        = multiplier;
               m_steps    = 0;
               m_sel_zero = 1'b0;
            end
         end else begin
            m_steps++;
            if (m_steps == W) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_prod = P'(longint'(m_a) * longint'(m_q));
            end
         end
      end
   end

   // Compare DUT outputs against the model every cycle once reset has been seen.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("product", product, m_prod);
         if (m_busy) begin
            // After k steps the decode pair is {Q bit k, Q bit k-1} of the original multiplier.
            e_sel[1] = m_q[m_steps];
            e_sel[0] = (m_steps == 0) ? 1'b0 : m_q[m_steps-1];
            chk("booth_sel", booth_sel, e_sel);
         end else if (m_sel_zero) begin
            chk("booth_sel_idle", booth_sel, 2'b00);
         end
      end
   end

   // ---------------- directed helpers ----------------
   // Called at posedge+2; returns at posedge+2 of the accepting edge.
   task automatic go(input logic [W-1:0] mc, input logic [W-1:0] mp);
      multiplicand = mc;
      multiplier   = mp;
      start        = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   // Returns at the negedge of the done cycle.
   task automatic wait_done(input string name, input logic [P-1:0] exp, input int exp_busy);
      int nb   = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (busy) nb++;
      end
      chk({name, " done_seen"}, seen, 1'b1);
      chk({name, " busy_cycles"}, nb, exp_busy);
      chk({name, " product"}, product, exp);
   endtask

   function automatic logic [W-1:0] rand_op();
      case ($urandom % 8)
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'hFFFF;
         3:       return 16'h0000;
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rnd_done;
      bit saw_done;
      rst          = 1'b1;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (2) @(posedge clk);
      #2;
      @(negedge clk);
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset product", product, 32'h0);
      chk("reset booth_sel", booth_sel, 2'b00);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Basic product and latency.
      go(16'd3, 16'd5);
      wait_done("3x5", 32'h0000000F, 16);
      @(posedge clk); #2;

      // Negative operand; product must hold after done falls.
      go(16'hFFF9, 16'd6);
      wait_done("-7x6", 32'hFFFFFFD6, 16);
      @(posedge clk); #2;
      @(negedge clk);
      chk("-7x6 hold", product, 32'hFFFFFFD6);
      chk("-7x6 done_low", done, 1'b0);
      @(posedge clk); #2;

      // Extreme operands.
      go(16'h8000, 16'h8000);
      wait_done("min x min", 32'h40000000, 16);
      @(posedge clk); #2;
      go(16'h8000, 16'h0001);
      wait_done("min x 1", 32'hFFFF8000, 16);
      @(posedge clk); #2;

      // Start while busy is ignored, then back-to-back start in the done cycle.
      go(16'd3, 16'd5);
      repeat (4) @(posedge clk);
      #2;
      multiplicand = 16'd2;
      multiplier   = 16'd2;
      start        = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      wait_done("busy start ignored", 32'h0000000F, 11);
      multiplicand = 16'd2;
      multiplier   = 16'd2;
      start        = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      wait_done("back to back", 32'h00000004, 16);
      @(posedge clk); #2;

      // Reset in the middle of an operation.
      go(16'd100, 16'd100);
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk);
      chk("abort busy", busy, 1'b0);
      chk("abort done", done, 1'b0);
      chk("abort product", product, 32'h0);
      saw_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("abort no done", saw_done, 1'b0);
      @(posedge clk); #2;
      go(16'h7FFF, 16'h7FFF);
      wait_done("max x max", 32'h3FFF0001, 16);
      @(posedge clk); #2;

      // Decode visibility.
      go(16'd1, 16'd2);
      @(negedge clk);
      chk("sel step0", booth_sel, 2'b00);
      @(negedge clk);
      chk("sel step1", booth_sel, 2'b10);
      @(negedge clk);
      chk("sel step2", booth_sel, 2'b01);
      wait_done("1x2", 32'h00000002, 13);
      @(posedge clk); #2;

      // Randomized traffic, including starts while busy and occasional resets.
      rnd_done = 0;
      for (int c = 0; c < 4000; c++) begin
         multiplicand = rand_op();
         multiplier   = rand_op();
         start        = (($urandom % 3) == 0);
         rst          = (($urandom % 400) == 0);
         @(posedge clk); #2;
         if (m_done) rnd_done++;
      end
      rst   = 1'b0;
      start = 1'b0;
      chk("random completions", (rnd_done > 20), 1'b1);
      repeat (20) @(posedge clk);
      #2;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
